// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store bus sequencer with byte-lane shifting and timeout.
// Define MISALIGN_SPLIT_EN to split misaligned accesses into two bus beats.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        LSE,
  input  logic        MEM_WE,
  input  logic [2:0]  LST,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        STALL,
  output logic [31:0] RDATA,
  output logic        LD_VALID,
  output logic        ERR,
  output logic        BUS_VALID,
  input  logic        BUS_READY,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_WSTRB,
  output logic [31:0] BUS_WDATA,
  input  logic [31:0] BUS_RDATA
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] BEAT0 = 3'd1;
  localparam logic [2:0] BEAT1 = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] FAULT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [1:0]  off;
  logic        is_w, is_h;
  logic        misal, split;
  logic        in_beat, tmo, valid, acc, last;
  logic [3:0]  strb_base, strb_sel;
  logic [31:0] wd_sel, rsh, mask;
  logic        unused_lst2;

  assign off         = ADDR[1:0];
  assign unused_lst2 = LST[2];

  // 011 and 11x fall through to word
  assign is_w = LST[1];
  assign is_h = !LST[1] && LST[0];

  assign misal = (is_h && off == 2'd3) ||
                 (is_w && off != 2'd0);

  assign strb_base = is_w ? 4'b1111 :
                     is_h ? 4'b0011 : 4'b0001;
  assign mask      = is_w ? 32'hFFFF_FFFF :
                     is_h ? 32'h0000_FFFF :
                            32'h0000_00FF;

  assign in_beat = (state_q == BEAT0) ||
                   (state_q == BEAT1);
  assign tmo     = (TIMEOUT != 0) &&
                   (cnt_q == TW'(TIMEOUT));
  assign valid   = in_beat && !tmo;
  assign acc     = valid && BUS_READY;

`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;

  logic [31:0] beat0_q;
  logic        hi;
  logic [7:0]  strb8;
  logic [63:0] wd64;
  logic [63:0] rd64;

  assign split = misal;
  assign hi    = (state_q == BEAT1);
  assign strb8 = {4'b0000, strb_base} << off;
  assign wd64  = {32'd0, WDATA} << {off, 3'b000};
  assign rd64  = hi ? {BUS_RDATA, beat0_q}
                    : {32'd0, BUS_RDATA};

  assign strb_sel = hi ? strb8[7:4] : strb8[3:0];
  assign wd_sel   = hi ? wd64[63:32] : wd64[31:0];
  assign rsh      = 32'(rd64 >> {off, 3'b000});
  assign BUS_ADDR = valid ?
    {ADDR[31:2], 2'b00} + (hi ? 32'd4 : 32'd0) :
    32'd0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      beat0_q <= '0;
    end else if (state_q == BEAT0 && acc && split) begin
      beat0_q <= BUS_RDATA;
    end
  end
`else
  localparam bit SPLIT_EN = 1'b0;

  assign split    = 1'b0;
  assign strb_sel = strb_base << off;
  assign wd_sel   = WDATA << {off, 3'b000};
  assign rsh      = BUS_RDATA >> {off, 3'b000};
  assign BUS_ADDR = valid ? {ADDR[31:2], 2'b00} : 32'd0;
`endif

  assign last = acc && ((state_q == BEAT1) || !split);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (LSE) begin
          state_d = (misal && !SPLIT_EN) ? FAULT : BEAT0;
        end
      end
      BEAT0: begin
        if (tmo) begin
          state_d = FAULT;
        end else if (acc) begin
          state_d = split ? BEAT1 : DONE;
        end
      end
      BEAT1: begin
        if (tmo) begin
          state_d = FAULT;
        end else if (acc) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (last && !MEM_WE) begin
      rdata_d = rsh & mask;
    end
    // counter restarts on every beat and saturates when the timeout is off
    if (state_d != state_q || acc) begin
      cnt_d = '0;
    end else if (valid && cnt_q != '1) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign STALL     = (state_q == IDLE) ? LSE : in_beat;
  assign LD_VALID  = (state_q == DONE) && !MEM_WE;
  assign ERR       = (state_q == FAULT);
  assign RDATA     = rdata_q;
  assign BUS_VALID = valid;
  assign BUS_WE    = valid && MEM_WE;
  assign BUS_WSTRB = (valid && MEM_WE) ? strb_sel : 4'b0000;
  assign BUS_WDATA = (valid && MEM_WE) ? wd_sel : 32'd0;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: directed scoreboard bench for lsu_bus_ctrl (TIMEOUT=4).
module tb_lsu_bus_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        LSE;
  logic        MEM_WE;
  logic [2:0]  LST;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic        STALL;
  logic [31:0] RDATA;
  logic        LD_VALID;
  logic        ERR;
  logic        BUS_VALID;
  logic        BUS_READY;
  logic        BUS_WE;
  logic [31:0] BUS_ADDR;
  logic [3:0]  BUS_WSTRB;
  logic [31:0] BUS_WDATA;
  logic [31:0] BUS_RDATA;

  int checks = 0;
  int errors = 0;
  logic [33:0] sb[$];

  always #5 CLK = ~CLK;

  lsu_bus_ctrl #(.TIMEOUT(4), .TW(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .LSE(LSE), .MEM_WE(MEM_WE),
    .LST(LST), .ADDR(ADDR), .WDATA(WDATA), .STALL(STALL),
    .RDATA(RDATA), .LD_VALID(LD_VALID), .ERR(ERR),
    .BUS_VALID(BUS_VALID), .BUS_READY(BUS_READY),
    .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_WSTRB(BUS_WSTRB), .BUS_WDATA(BUS_WDATA),
    .BUS_RDATA(BUS_RDATA)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 store done, 1 load data, 2 fault
  task automatic access(
    input string tag, input logic we, input logic [2:0] lst,
    input logic [31:0] addr, input logic [31:0] wd, input int waits,
    input logic [31:0] rd0, input logic [31:0] rd1,
    input logic [3:0] s0, input logic [3:0] s1,
    input logic [31:0] w0, input logic [31:0] w1,
    input logic [1:0] kind, input logic [31:0] erd,
    input int envalid, input int enstall);
    int w, beat, nvalid, nstall;
    logic fin;
    logic [1:0] okind;
    logic [33:0] e;
    sb.push_back({kind, erd});
    LSE = 1'b1; MEM_WE = we; LST = lst;
    ADDR = addr; WDATA = wd; BUS_READY = 1'b0;
    w = waits; beat = 0; nvalid = 0; nstall = 0;
    fin = 1'b0; okind = 2'd0;
    #1;
    if (STALL) nstall++;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(posedge CLK); #1;
      BUS_READY = 1'b0;
      #1;
      if (STALL) nstall++;
      if (BUS_VALID) begin
        nvalid++;
        chk({tag, "_addr"}, BUS_ADDR,
            {addr[31:2], 2'b00} + (beat != 0 ? 32'd4 : 32'd0));
        chk({tag, "_we"}, 32'(BUS_WE), 32'(we));
        chk({tag, "_strb"}, 32'(BUS_WSTRB),
            32'(beat != 0 ? s1 : s0));
        if (we) begin
          chk({tag, "_wdata"}, BUS_WDATA, beat != 0 ? w1 : w0);
        end
        if (w == 0) begin
          BUS_READY = 1'b1;
          BUS_RDATA = (beat != 0) ? rd1 : rd0;
          beat++;
          w = waits;
        end else begin
          w--;
        end
      end else if (!STALL) begin
        fin = 1'b1;
        okind = ERR ? 2'd2 : (LD_VALID ? 2'd1 : 2'd0);
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $error("FAIL %s_hang: observed no completion expected done", tag);
    end
    e = sb.pop_front();
    chk({tag, "_kind"}, 32'(okind), 32'(e[33:32]));
    if (e[33:32] == 2'd1) begin
      chk({tag, "_rdata"}, RDATA, e[31:0]);
    end
    chk({tag, "_nvalid"}, 32'(nvalid), 32'(envalid));
    chk({tag, "_nstall"}, 32'(nstall), 32'(enstall));
    LSE = 1'b0;
    BUS_READY = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    RST_N = 1'b0; LSE = 1'b0; MEM_WE = 1'b0; LST = 3'b000;
    ADDR = '0; WDATA = '0; BUS_READY = 1'b0; BUS_RDATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_stall", 32'(STALL), 32'd0);
    chk("rst_valid", 32'(BUS_VALID), 32'd0);
    chk("rst_ldv", 32'(LD_VALID), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_strb", 32'(BUS_WSTRB), 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    access("sw", 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 2,
           32'd0, 32'd0, 4'b1111, 4'b0000,
           32'hDEAD_BEEF, 32'd0, 2'd0, 32'd0, 3, 4);
    access("lb", 1'b0, 3'b000, 32'h203, 32'd0, 0,
           32'h8011_2233, 32'd0, 4'b0000, 4'b0000,
           32'd0, 32'd0, 2'd1, 32'h0000_0080, 1, 2);
    access("sh", 1'b1, 3'b001, 32'h302, 32'h0000_ABCD, 0,
           32'd0, 32'd0, 4'b1100, 4'b0000,
           32'hABCD_0000, 32'd0, 2'd0, 32'd0, 1, 2);
    chk("st_keeps_rdata", RDATA, 32'h0000_0080);
    access("lhu", 1'b0, 3'b101, 32'h202, 32'd0, 0,
           32'h8011_2233, 32'd0, 4'b0000, 4'b0000,
           32'd0, 32'd0, 2'd1, 32'h0000_8011, 1, 2);
    access("lh1", 1'b0, 3'b001, 32'h201, 32'd0, 0,
           32'h8011_2233, 32'd0, 4'b0000, 4'b0000,
           32'd0, 32'd0, 2'd1, 32'h0000_1122, 1, 2);
    access("lbu", 1'b0, 3'b100, 32'h201, 32'd0, 1,
           32'h8011_2233, 32'd0, 4'b0000, 4'b0000,
           32'd0, 32'd0, 2'd1, 32'h0000_0022, 2, 3);
    access("sb", 1'b1, 3'b000, 32'h103, 32'h1234_56A5, 0,
           32'd0, 32'd0, 4'b1000, 4'b0000,
           32'hA500_0000, 32'd0, 2'd0, 32'd0, 1, 2);
    access("lw111", 1'b0, 3'b111, 32'h700, 32'd0, 1,
           32'h0102_0304, 32'd0, 4'b0000, 4'b0000,
           32'd0, 32'd0, 2'd1, 32'h0102_0304, 2, 3);
    access("sw110", 1'b1, 3'b110, 32'h704, 32'h55AA_55AA, 0,
           32'd0, 32'd0, 4'b1111, 4'b0000,
           32'h55AA_55AA, 32'd0, 2'd0, 32'd0, 1, 2);

`ifdef MISALIGN_SPLIT_EN
    access("lw_mis", 1'b0, 3'b010, 32'h401, 32'd0, 0,
           32'h4433_2211, 32'h8877_6655, 4'b0000, 4'b0000,
           32'd0, 32'd0, 2'd1, 32'h5544_3322, 2, 3);
    access("sh_mis", 1'b1, 3'b001, 32'h103, 32'h0000_BEEF, 0,
           32'd0, 32'd0, 4'b1000, 4'b0001,
           32'hEF00_0000, 32'h0000_00BE, 2'd0, 32'd0, 2, 3);
`else
    access("lw_mis", 1'b0, 3'b010, 32'h401, 32'd0, 0,
           32'h4433_2211, 32'h8877_6655, 4'b0000, 4'b0000,
           32'd0, 32'd0, 2'd2, 32'd0, 0, 1);
    access("sh_mis", 1'b1, 3'b001, 32'h103, 32'h0000_BEEF, 0,
           32'd0, 32'd0, 4'b0000, 4'b0000,
           32'd0, 32'd0, 2'd2, 32'd0, 0, 1);
`endif

    access("tmo", 1'b0, 3'b010, 32'h500, 32'd0, 1000,
           32'd0, 32'd0, 4'b0000, 4'b0000,
           32'd0, 32'd0, 2'd2, 32'd0, 4, 6);
    chk("tmo_stall_rel", 32'(STALL), 32'd0);

    LSE = 1'b1; MEM_WE = 1'b0; LST = 3'b010;
    ADDR = 32'h600; BUS_READY = 1'b0;
    @(posedge CLK); #1;
    chk("rst_mid_valid_pre", 32'(BUS_VALID), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(BUS_VALID), 32'd0);
    chk("rst_mid_err", 32'(ERR), 32'd0);
    chk("rst_mid_ldv", 32'(LD_VALID), 32'd0);
    chk("rst_mid_rdata", RDATA, 32'd0);
    LSE = 1'b0;
    #1;
    chk("rst_mid_stall", 32'(STALL), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_err", 32'(ERR), 32'd0);
    chk("post_rst_ldv", 32'(LD_VALID), 32'd0);
    chk("post_rst_valid", 32'(BUS_VALID), 32'd0);

    access("lw_after_rst", 1'b0, 3'b010, 32'h600, 32'd0, 1,
           32'hCAFE_F00D, 32'd0, 4'b0000, 4'b0000,
           32'd0, 32'd0, 2'd1, 32'hCAFE_F00D, 2, 3);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
